hack_memory_io: RTL and testbench



---
 rtl/hack_pkg.sv | 21 ++
 rtl/hack_kbd_fifo.sv | 55 +++++
 rtl/hack_memory_io.sv | 115 +++++++++++
 tb/tb_hack_memory_io.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared constants for the Hack data-memory subsystem.
// Keyboard register offsets, status bit positions and region decode.
package hack_pkg;

    localparam logic [1:0] KBD_DATA_OFS = 2'd0;
    localparam logic [1:0] KBD_STAT_OFS = 2'd1;
    localparam logic [1:0] TICK_OFS     = 2'd2;

    localparam int ST_NONEMPTY  = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_DROP      = 2;
    localparam int ST_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_SCR,
        REG_KBD,
        REG_NONE
    } region_t;

endpackage

// File: rtl/hack_kbd_fifo.sv
// Keyboard scan-code FIFO with sticky drop flag.
// Head is valid only while empty is low.
module hack_kbd_fifo #(
    parameter int DW        = 16,
    parameter int KBD_DEPTH = 8,
    localparam int PW = $clog2(KBD_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push_valid,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          clr_drop,
    output logic [DW-1:0] head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          drop
);

    logic [DW-1:0] mem [KBD_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(KBD_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push_valid && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // An offer while full outranks a same-cycle clear so no drop is lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            drop   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
            if (push_valid && full) drop <= 1'b1;
            else if (clr_drop)      drop <= 1'b0;
        end
    end

endmodule

// File: rtl/hack_memory_io.sv
// Hack data memory: RAM, screen with scan-out port, buffered keyboard.
// Define HACK_MEM_TICK_EN to map a free-running cycle counter at KBD_ADDR+2.
module hack_memory_io
    import hack_pkg::*;
#(
    parameter int DW        = 16,
    parameter int RAM_AW    = 14,
    parameter int SCR_AW    = 13,
    parameter int KBD_DEPTH = 8,
    localparam int AW = RAM_AW + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DW-1:0]     in,
    input  logic              load,
    input  logic [AW-1:0]     address,
    output logic [DW-1:0]     out,
    input  logic [SCR_AW-1:0] scan_addr,
    output logic [DW-1:0]     scan_data,
    input  logic              key_valid,
    input  logic [DW-1:0]     key_code,
    output logic              key_ready
);

    localparam int CW = $clog2(KBD_DEPTH) + 1;
    localparam logic [AW-1:0] KBD_ADDR = AW'(3) << (AW - 2);

    logic [DW-1:0] ram [2**RAM_AW];
    logic [DW-1:0] scr [2**SCR_AW];

    region_t       region;
    logic [1:0]    ofs;
    logic          kbd_pop;
    logic          kbd_clr;
    logic [DW-1:0] head;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          drop;
    logic [DW-1:0] status;

    assign ofs = address[1:0];

    always_comb begin
        region = REG_NONE;
        if (!address[AW-1])                      region = REG_RAM;
        else if (!address[AW-2])                 region = REG_SCR;
        else if (address[AW-1:2] == KBD_ADDR[AW-1:2]) region = REG_KBD;
    end

    // Memory arrays are deliberately not gated by reset.
    always_ff @(posedge clock) begin
        if (load && region == REG_RAM) ram[address[RAM_AW-1:0]] <= in;
        if (load && region == REG_SCR) scr[address[SCR_AW-1:0]] <= in;
    end

    assign scan_data = scr[scan_addr];

    assign kbd_pop = load && region == REG_KBD && ofs == KBD_DATA_OFS;
    assign kbd_clr = load && region == REG_KBD && ofs == KBD_STAT_OFS;

    hack_kbd_fifo #(
        .DW        (DW),
        .KBD_DEPTH (KBD_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_valid (key_valid),
        .push_data  (key_code),
        .pop        (kbd_pop),
        .clr_drop   (kbd_clr),
        .head       (head),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .drop       (drop)
    );

    assign key_ready = !full;

    always_comb begin
        status                       = '0;
        status[ST_NONEMPTY]          = !empty;
        status[ST_FULL]              = full;
        status[ST_DROP]              = drop;
        status[ST_COUNT_LSB +: CW]   = count;
    end

`ifdef HACK_MEM_TICK_EN
    logic [DW-1:0] tick;

    always_ff @(posedge clock) begin
        if (reset)                                     tick <= '0;
        else if (load && region == REG_KBD && ofs == TICK_OFS) tick <= '0;
        else                                           tick <= tick + 1'b1;
    end
`endif

    always_comb begin
        out = '0;
        unique case (region)
            REG_RAM: out = ram[address[RAM_AW-1:0]];
            REG_SCR: out = scr[address[SCR_AW-1:0]];
            REG_KBD: begin
                if (ofs == KBD_DATA_OFS)      out = empty ? '0 : head;
                else if (ofs == KBD_STAT_OFS) out = status;
`ifdef HACK_MEM_TICK_EN
                else if (ofs == TICK_OFS)     out = tick;
`endif
            end
            default: out = '0;
        endcase
    end

endmodule

// File: tb/tb_hack_memory_io.sv
// Directed scoreboard bench for hack_memory_io at default parameters.
module tb_hack_memory_io;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] din   = '0;
    logic        load  = 1'b0;
    logic [14:0] address = '0;
    logic [15:0] dout;
    logic [12:0] scan_addr = '0;
    logic [15:0] scan_data;
    logic        key_valid = 1'b0;
    logic [15:0] key_code  = '0;
    logic        key_ready;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q [$];
    string       tag_q [$];
    logic [15:0] t1;

    hack_memory_io dut (
        .clock     (clock),
        .reset     (reset),
        .in        (din),
        .load      (load),
        .address   (address),
        .out       (dout),
        .scan_addr (scan_addr),
        .scan_data (scan_data),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [14:0] a, input logic [15:0] e,
                      input string tag);
        address = a;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #1;
        chk(tag_q.pop_front(), dout, exp_q.pop_front());
    endtask

    task automatic wr(input logic [14:0] a, input logic [15:0] d);
        address = a;
        din     = d;
        load    = 1'b1;
        step();
        load    = 1'b0;
    endtask

    task automatic push(input logic [15:0] c);
        key_code  = c;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        chk("rst_ready", 16'(key_ready), 16'd1);
        rd(15'h6000, 16'h0000, "rst_kbd");
        rd(15'h6001, 16'h0000, "rst_stat");

        wr(15'h0006, 16'hBEEF);
        wr(15'h0005, 16'h1234);
        rd(15'h0005, 16'h1234, "ram5");
        rd(15'h0006, 16'hBEEF, "ram6");

        wr(15'h0000, 16'h5A5A);
        wr(15'h4000, 16'hFFFF);
        wr(15'h5FFF, 16'h00C3);
        scan_addr = 13'd0;
        #1;
        chk("scan0", scan_data, 16'hFFFF);
        scan_addr = 13'h1FFF;
        #1;
        chk("scan_top", scan_data, 16'h00C3);
        rd(15'h4000, 16'hFFFF, "scr_rd");
        rd(15'h0000, 16'h5A5A, "ram0_kept");

        push(16'd65);
        push(16'd66);
        rd(15'h6000, 16'd65, "kbd_head65");
        rd(15'h6001, 16'h0201, "stat2");
        wr(15'h6000, 16'h0000);
        rd(15'h6000, 16'd66, "kbd_head66");
        wr(15'h6000, 16'h0000);
        rd(15'h6000, 16'h0000, "kbd_empty");
        rd(15'h6001, 16'h0000, "stat_empty");
        wr(15'h6000, 16'h0000);
        rd(15'h6001, 16'h0000, "pop_empty");

        for (int i = 0; i < 8; i++) begin
            key_code  = 16'(10 + i);
            key_valid = 1'b1;
            step();
        end
        key_valid = 1'b0;
        chk("full_ready", 16'(key_ready), 16'd0);
        rd(15'h6001, 16'h0803, "stat_full");
        push(16'd99);
        rd(15'h6001, 16'h0807, "stat_drop");
        key_code  = 16'd99;
        key_valid = 1'b1;
        wr(15'h6000, 16'h0000);
        key_valid = 1'b0;
        rd(15'h6001, 16'h0705, "pop_offer");
        rd(15'h6000, 16'd11, "head11");
        wr(15'h6001, 16'h0000);
        rd(15'h6001, 16'h0701, "drop_clr");
        for (int i = 11; i < 18; i++) begin
            rd(15'h6000, 16'(i), $sformatf("drain%0d", i));
            wr(15'h6000, 16'h0000);
        end
        rd(15'h6000, 16'h0000, "drained");

        push(16'd1);
        push(16'd2);
        push(16'd3);
        rd(15'h6001, 16'h0301, "stat3");
        reset     = 1'b1;
        key_code  = 16'd4;
        key_valid = 1'b1;
        wr(15'h0007, 16'h7777);
        reset     = 1'b0;
        key_valid = 1'b0;
        rd(15'h6001, 16'h0000, "rst_mid_stat");
        rd(15'h6000, 16'h0000, "rst_mid_kbd");
        chk("rst_mid_ready", 16'(key_ready), 16'd1);
        rd(15'h0005, 16'h1234, "ram_retained");
        rd(15'h0007, 16'h7777, "wr_in_reset");

        wr(15'h7000, 16'hABCD);
        rd(15'h7000, 16'h0000, "unmapped7000");
        rd(15'h6003, 16'h0000, "unmapped6003");
`ifdef HACK_MEM_TICK_EN
        address = 15'h6002;
        #1;
        t1 = dout;
        repeat (10) step();
        rd(15'h6002, t1 + 16'd10, "tick_diff");
        wr(15'h6002, 16'h5555);
        rd(15'h6002, 16'h0000, "tick_clr");
        step();
        rd(15'h6002, 16'h0001, "tick_inc");
`else
        t1 = '0;
        wr(15'h6002, 16'h5555);
        rd(15'h6002, t1, "unmapped6002");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
